// File: rtl/rr_mux4_arbiter_if.sv
// Bus bundle for rr_mux4_arbiter: four requesters with data, a one-hot grant
// back to them, and the registered output stage with its valid/ready handshake.
//   req       [3:0]        request per source (0=a, 1=b, 2=c, 3=d)
//   a,b,c,d   [WIDTH-1:0]  source words, stable while the matching req is high
//   gnt       [3:0]        one-cycle one-hot pulse: that source's word was captured
//   sel       [1:0]        index of the source held in the output stage
//   out_data  [WIDTH-1:0]  captured word
//   out_valid              out_data/sel valid
//   out_ready              consumer accepts when out_valid & out_ready
// master: the arbiter side. slave: the environment (requesters + consumer).
interface rr_mux4_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  req, a, b, c, d, out_ready,
    output gnt, sel, out_data, out_valid
  );

  modport slave (
    output req, a, b, c, d, out_ready,
    input  gnt, sel, out_data, out_valid
  );
endinterface

// File: rtl/rr_mux4_arbiter.sv
// Round-robin 4:1 arbiter/mux with a single registered output stage.
// A rotating pointer picks the first eligible requester at or after it, the
// winner's word is captured into the output stage, and a one-cycle grant tells
// the source its word was taken. The stage refills back-to-back while the
// consumer is ready.
//   clk   clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   rr_mux4_arbiter_if.master (requests, data, grant, output handshake)
module rr_mux4_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  rr_mux4_arbiter_if.master bus
);

  typedef enum logic [0:0] {StIdle, StFull} state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_ptr,   w_ptr_d;
  logic [3:0]       r_gnt,   w_gnt_d;
  logic [1:0]       r_sel,   w_sel_d;
  logic [WIDTH-1:0] r_data,  w_data_d;

  logic [3:0]       w_elig;
  logic [1:0]       w_idx;
  logic [1:0]       w_win;
  logic             w_any;
  logic [WIDTH-1:0] w_word;
  logic             w_capture;

  // A source granted last edge still shows req this cycle; mask it so the
  // same request cannot win twice.
  assign w_elig = bus.req & ~r_gnt;

  // Scan from the highest offset down so the lowest offset from r_ptr wins.
  always_comb begin
    w_idx = 2'd0;
    w_win = 2'd0;
    w_any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (w_elig[w_idx]) begin
        w_win = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_comb begin
    w_word = bus.a;
    unique case (w_win)
      2'd0: w_word = bus.a;
      2'd1: w_word = bus.b;
      2'd2: w_word = bus.c;
      2'd3: w_word = bus.d;
    endcase
  end

  // Capture whenever the stage is empty or being drained this edge.
  assign w_capture = w_any && ((r_state == StIdle) || bus.out_ready);

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_gnt_d   = 4'b0000;
    w_sel_d   = r_sel;
    w_data_d  = r_data;
    unique case (r_state)
      StIdle: if (w_capture) w_state_d = StFull;
      StFull: if (bus.out_ready && !w_any) w_state_d = StIdle;
    endcase
    if (w_capture) begin
      w_data_d = w_word;
      w_sel_d  = w_win;
      w_gnt_d  = 4'b0001 << w_win;
      w_ptr_d  = w_win + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_ptr   <= 2'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_gnt   <= w_gnt_d;
      r_sel   <= w_sel_d;
      r_data  <= w_data_d;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.out_data  = r_data;
  assign bus.out_valid = (r_state == StFull);

endmodule
